cpu_clock_control: RTL and testbench

CPU_CLOCK_CONTROL -- requirements
Module: cpu_clock_control

---
 rtl/cpu_clock_control.sv | 92 +++++++++
 tb/tb_cpu_clock_control.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clock_control.sv
// cpu_clock_control: mode-selectable CPU clock enable (halt / single-step / slow / fast) with debounced buttons
module cpu_clock_control #(
    parameter int DEBOUNCE_CYCLES = 270_000
) (
    input  logic        clock_in,
    input  logic        reset,
    input  logic        slow_clock_in,
    input  logic        step_button_n,
    input  logic        mode_button_n,
    input  logic        halt_in,
    output logic        cpu_enable,
    output logic [1:0]  mode_out,
    output logic [15:0] enable_count,
    output logic        slow_led
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0] HALT = 2'b00;
    localparam logic [1:0] STEP = 2'b01;
    localparam logic [1:0] SLOW = 2'b10;
    localparam logic [1:0] FAST = 2'b11;

    // index 0 is the step button, index 1 the mode button
    logic [1:0]    btn_s1, btn_s2, btn_db, btn_db_d;
    logic [CW-1:0] btn_cnt [2];
    logic [1:0]    press;
    logic          step_press, mode_press;
    logic          slow_s1, slow_d, slow_rise;
    logic          en_q;

    assign press      = btn_db_d & ~btn_db;
    assign step_press = press[0];
    assign mode_press = press[1];
    // halt suppresses the enable in the very cycle it is requested
    assign cpu_enable = en_q & ~halt_in;

    // button synchronizers and debouncers; a level is accepted after DEBOUNCE_CYCLES stable cycles
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            btn_s1   <= 2'b11;
            btn_s2   <= 2'b11;
            btn_db   <= 2'b11;
            btn_db_d <= 2'b11;
            for (int i = 0; i < 2; i++) btn_cnt[i] <= '0;
        end else begin
            btn_s1   <= {mode_button_n, step_button_n};
            btn_s2   <= btn_s1;
            btn_db_d <= btn_db;
            for (int i = 0; i < 2; i++) begin
                if (btn_s2[i] == btn_db[i]) begin
                    btn_cnt[i] <= '0;
                end else if (btn_cnt[i] == CNT_MAX) begin
                    btn_cnt[i] <= '0;
                    btn_db[i]  <= btn_s2[i];
                end else begin
                    btn_cnt[i] <= btn_cnt[i] + 1'b1;
                end
            end
        end
    end

    // slow clock synchronizer and registered rising-edge pulse
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            slow_s1   <= 1'b0;
            slow_led  <= 1'b0;
            slow_d    <= 1'b0;
            slow_rise <= 1'b0;
        end else begin
            slow_s1   <= slow_clock_in;
            slow_led  <= slow_s1;
            slow_d    <= slow_led;
            slow_rise <= slow_led & ~slow_d;
        end
    end

    // mode FSM, enable generation and enable counter; halt beats a mode press, a mode press beats a step
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            mode_out     <= HALT;
            en_q         <= 1'b0;
            enable_count <= '0;
        end else begin
            mode_out     <= halt_in ? HALT : mode_press ? mode_out + 2'd1 : mode_out;
            en_q         <= !halt_in && !mode_press &&
                            ((mode_out == FAST) ||
                             (mode_out == STEP && step_press) ||
                             (mode_out == SLOW && slow_rise));
            enable_count <= cpu_enable ? enable_count + 16'd1 : enable_count;
        end
    end
endmodule

// File: tb/tb_cpu_clock_control.sv
// tb_cpu_clock_control: scoreboard bench for cpu_clock_control with DEBOUNCE_CYCLES=4
module tb_cpu_clock_control;
    logic        clock_in = 1'b0;
    logic        reset = 1'b1;
    logic        slow_clock_in = 1'b0;
    logic        step_button_n = 1'b1;
    logic        mode_button_n = 1'b1;
    logic        halt_in = 1'b0;
    logic        cpu_enable;
    logic [1:0]  mode_out;
    logic [15:0] enable_count;
    logic        slow_led;

    cpu_clock_control #(.DEBOUNCE_CYCLES(4)) dut (
        .clock_in(clock_in),
        .reset(reset),
        .slow_clock_in(slow_clock_in),
        .step_button_n(step_button_n),
        .mode_button_n(mode_button_n),
        .halt_in(halt_in),
        .cpu_enable(cpu_enable),
        .mode_out(mode_out),
        .enable_count(enable_count),
        .slow_led(slow_led)
    );

    typedef struct {
        int          cyc;
        logic [1:0]  mode;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [15:0] exp_cnt = 16'd0;
    bit          fast_on = 1'b0;
    int          fast_from = 0;

    always #5 clock_in = ~clock_in;

    // free-running cycle index, read at negedge by the monitor
    always @(posedge clock_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int c, input logic [1:0] m);
        exp_t e;
        e.cyc  = c;
        e.mode = m;
        e.cnt  = exp_cnt;
        sb.push_back(e);
        exp_cnt++;
    endtask

    // advance one cycle; h raises halt_in for the new cycle, otherwise FAST cycles expect an enable
    task automatic tick(input bit h = 1'b0);
        @(posedge clock_in);
        #1;
        halt_in = h;
        if (!h && fast_on && cyc >= fast_from) push(cyc, 2'd3);
    endtask

    // mode press held 10 cycles: state changes 7 cycles after the press is driven
    task automatic press_mode(input logic [1:0] from, input logic [1:0] to);
        mode_button_n = 1'b0;
        repeat (6) tick();
        chk("mode_before", mode_out, from);
        tick();
        chk("mode_after", mode_out, to);
        repeat (3) tick();
        mode_button_n = 1'b1;
        repeat (10) tick();
    endtask

    initial begin
        fork
            begin
                exp_t e;
                forever begin
                    @(negedge clock_in);
                    if (!reset && cpu_enable) begin
                        if (sb.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL unexpected_enable: cpu_enable=1 at cycle %0d, required 0", cyc);
                        end else begin
                            e = sb.pop_front();
                            chk("enable_cycle", cyc, e.cyc);
                            chk("enable_mode", mode_out, e.mode);
                            chk("enable_count", enable_count, e.cnt);
                        end
                    end
                end
            end
            begin
                int s0, r0, rr;
                repeat (3) tick();
                chk("rst_enable", cpu_enable, 0);
                chk("rst_mode", mode_out, 0);
                chk("rst_count", enable_count, 0);
                chk("rst_slow_led", slow_led, 0);
                reset = 1'b0;
                repeat (5) tick();
                press_mode(2'd0, 2'd1);
                s0 = cyc;
                push(s0 + 9, 2'd1);
                step_button_n = 1'b0;
                tick();
                step_button_n = 1'b1;
                tick();
                step_button_n = 1'b0;
                repeat (10) tick();
                step_button_n = 1'b1;
                repeat (10) tick();
                chk("step_count", enable_count, 16'd1);
                step_button_n = 1'b0;
                press_mode(2'd1, 2'd2);
                step_button_n = 1'b1;
                repeat (10) tick();
                chk("mode_wins_count", enable_count, 16'd1);
                step_button_n = 1'b0;
                repeat (10) tick();
                step_button_n = 1'b1;
                repeat (10) tick();
                r0 = cyc;
                slow_clock_in = 1'b1;
                push(r0 + 4, 2'd2);
                tick();
                chk("slow_led_lag", slow_led, 0);
                tick();
                chk("slow_led_high", slow_led, 1);
                repeat (4) tick();
                slow_clock_in = 1'b0;
                repeat (6) tick();
                r0 = cyc;
                slow_clock_in = 1'b1;
                push(r0 + 4, 2'd2);
                repeat (8) tick();
                slow_clock_in = 1'b0;
                repeat (6) tick();
                chk("slow_count", enable_count, 16'd3);
                fast_from = cyc + 8;
                fast_on = 1'b1;
                press_mode(2'd2, 2'd3);
                while (exp_cnt != 16'hFFFF) tick();
                chk("wrap_fffe", enable_count, 16'hFFFE);
                tick();
                chk("wrap_ffff", enable_count, 16'hFFFF);
                tick();
                chk("wrap_0000", enable_count, 16'h0000);
                tick();
                chk("wrap_0001", enable_count, 16'h0001);
                tick(1'b1);
                #1;
                chk("halt_enable", cpu_enable, 0);
                chk("halt_mode_same", mode_out, 3);
                fast_on = 1'b0;
                tick();
                chk("halt_mode", mode_out, 0);
                chk("halt_enable_after", cpu_enable, 0);
                repeat (5) tick();
                chk("halt_count", enable_count, 16'd2);
                press_mode(2'd0, 2'd1);
                press_mode(2'd1, 2'd2);
                exp_cnt = enable_count;
                fast_from = cyc + 8;
                fast_on = 1'b1;
                press_mode(2'd2, 2'd3);
                slow_clock_in = 1'b1;
                repeat (4) tick();
                mode_button_n = 1'b0;
                repeat (3) tick();
                fast_on = 1'b0;
                reset = 1'b1;
                sb.delete();
                #1;
                chk("arst_enable", cpu_enable, 0);
                chk("arst_mode", mode_out, 0);
                chk("arst_count", enable_count, 0);
                chk("arst_slow_led", slow_led, 0);
                exp_cnt = 16'd0;
                repeat (2) tick();
                reset = 1'b0;
                rr = cyc;
                repeat (6) tick();
                chk("post_rst_mode_hold", mode_out, 0);
                tick();
                chk("post_rst_mode_step", mode_out, 1);
                chk("post_rst_cycle", cyc, rr + 7);
                repeat (3) tick();
                mode_button_n = 1'b1;
                repeat (12) tick();
                chk("post_rst_mode_final", mode_out, 1);
                chk("pending_enables", sb.size(), 0);
            end
        join_any
        disable fork;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
